mem_arb_rvdmem: RTL and testbench

- Two-requester arbiter sharing one single-port synchronous data memory (DEPTH words, DATA_WIDTH wide, byte write enables, write-first, 1-cycle read latency).
- Port 0 = core load/store unit; port 1 = loader/debug master.
- Grants one request per cycle and routes the memory's registered read data back to the owner one cycle later.
- Provides a lock so a requester can hold the memory for read-modify-write sequences.

---
 rtl/mem_arb_rvdmem.sv | 127 ++++++++++++
 tb/tb_mem_arb_rvdmem.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arb_rvdmem.sv
// Two-port arbiter in front of one single-port synchronous data memory, with a per-port lock.
// Define MEM_ARB_RR_EN for round-robin conflict resolution; otherwise port 0 wins every conflict.
//
// lock_state | meaning
// UNLOCKED   | either port may be granted; conflicts resolved by priority policy
// LOCKED0    | only port 0 may be granted; port 1 is held off
// LOCKED1    | only port 1 may be granted; port 0 is held off
module mem_arb_rvdmem #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = DATA_WIDTH,
    parameter int DATA_BYTES = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic                  req0_lock,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_BYTES-1:0] req0_wen,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic                  req1_lock,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_BYTES-1:0] req1_wen,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [DATA_BYTES-1:0] mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        LOCKED0  = 2'd1,
        LOCKED1  = 2'd2
    } lock_state_t;

    lock_state_t lock_state, lock_state_nxt;
    logic        rsp_pending, rsp_owner;
    logic        grant0, grant1, prio0;

`ifdef MEM_ARB_RR_EN
    logic rr_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (grant0 || grant1) begin
            rr_last <= grant1;
        end
    end

    // Port 0 wins a conflict only when port 1 was the last one served.
    assign prio0 = rr_last;
`else
    assign prio0 = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_state <= UNLOCKED;
        end else begin
            lock_state <= lock_state_nxt;
        end
    end

    // Grants are suppressed while in reset so no write reaches the memory.
    always_comb begin
        grant0         = 1'b0;
        grant1         = 1'b0;
        lock_state_nxt = lock_state;
        if (!rst) begin
            case (lock_state)
                UNLOCKED: begin
                    grant0 = req0_valid && (!req1_valid || prio0);
                    grant1 = req1_valid && !grant0;
                end
                LOCKED0: grant0 = req0_valid;
                LOCKED1: grant1 = req1_valid;
                default: ;
            endcase
        end
        if (grant0) begin
            if (req0_lock) begin
                lock_state_nxt = LOCKED0;
            end else if (lock_state == LOCKED0) begin
                lock_state_nxt = UNLOCKED;
            end
        end else if (grant1) begin
            if (req1_lock) begin
                lock_state_nxt = LOCKED1;
            end else if (lock_state == LOCKED1) begin
                lock_state_nxt = UNLOCKED;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    assign mem_addr  = grant1 ? req1_addr  : req0_addr;
    assign mem_wdata = grant1 ? req1_wdata : req0_wdata;
    assign mem_wen   = grant1 ? req1_wen : (grant0 ? req0_wen : '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_pending <= 1'b0;
            rsp_owner   <= 1'b0;
        end else begin
            rsp_pending <= grant0 || grant1;
            if (grant0 || grant1) begin
                rsp_owner <= grant1;
            end
        end
    end

    assign rsp0_valid = rsp_pending && !rsp_owner;
    assign rsp1_valid = rsp_pending && rsp_owner;
    assign rsp0_rdata = mem_rdata;
    assign rsp1_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arb_rvdmem.sv
// Bench for mem_arb_rvdmem: directed vector table, reset corner sequence, then random traffic
// checked against a transaction-level model of the arbiter and memory.
module tb_mem_arb_rvdmem;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req0_lock;
    logic [63:0] req0_addr, req0_wdata;
    logic [7:0]  req0_wen;
    logic        req1_valid, req1_ready, req1_lock;
    logic [63:0] req1_addr, req1_wdata;
    logic [7:0]  req1_wen;
    logic        rsp0_valid, rsp1_valid;
    logic [63:0] rsp0_rdata, rsp1_rdata;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wen;

    always #5 clk = ~clk;

    mem_arb_rvdmem dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_wen(req0_wen),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_wen(req1_wen),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wen(mem_wen),
        .mem_rdata(mem_rdata)
    );

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Single-port write-first memory with one cycle of read latency.
    logic [63:0] mem_arr [0:1023];
    always @(posedge clk) begin
        logic [63:0] w;
        w = merge(mem_arr[mem_addr[12:3]], mem_wdata, mem_wen);
        mem_arr[mem_addr[12:3]] = w;
        mem_rdata <= w;
    end

    typedef struct {
        logic        v0, l0, v1, l1;
        logic [63:0] a0, d0, a1, d1;
        logic [7:0]  w0, w1;
        logic        er0, er1, ev0, ev1;
        logic [63:0] erd;
    } vec_t;

    function automatic vec_t mk(input logic v0, input logic l0, input logic [63:0] a0,
                                input logic [7:0] w0, input logic [63:0] d0,
                                input logic v1, input logic l1, input logic [63:0] a1,
                                input logic [7:0] w1, input logic [63:0] d1,
                                input logic er0, input logic er1, input logic ev0,
                                input logic ev1, input logic [63:0] erd);
        vec_t v;
        v.v0 = v0; v.l0 = l0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
        v.v1 = v1; v.l1 = l1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
        v.er0 = er0; v.er1 = er1; v.ev0 = ev0; v.ev1 = ev1; v.erd = erd;
        return v;
    endfunction

    // Reference model state
    logic [63:0] shadow [0:1023];
    int          lock_own;
    int          rr_last_m;
    bit          pend;
    int          pend_owner;
    logic [63:0] pend_data;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic run_cycle(input vec_t v, input logic r);
        int          g;
        logic [63:0] ea, ed, nw;
        logic [7:0]  ew;
        logic        lk;
        @(negedge clk);
        rst = r;
        req0_valid = v.v0; req0_lock = v.l0; req0_addr = v.a0; req0_wdata = v.d0; req0_wen = v.w0;
        req1_valid = v.v1; req1_lock = v.l1; req1_addr = v.a1; req1_wdata = v.d1; req1_wen = v.w1;
        #1;
        if (r) begin
            pend = 0; lock_own = -1; rr_last_m = 1;
        end
        g = -1;
        if (!r) begin
            if (lock_own >= 0) begin
                if ((lock_own == 0) ? v.v0 : v.v1) g = lock_own;
            end else if (v.v0 && v.v1) g = RR ? 1 - rr_last_m : 0;
            else if (v.v0) g = 0;
            else if (v.v1) g = 1;
        end
        ea = (g == 1) ? v.a1 : v.a0;
        ed = (g == 1) ? v.d1 : v.d0;
        ew = (g == 1) ? v.w1 : ((g == 0) ? v.w0 : 8'h00);
        chk("req0_ready", {63'd0, req0_ready}, {63'd0, g == 0});
        chk("req1_ready", {63'd0, req1_ready}, {63'd0, g == 1});
        chk("rsp0_valid", {63'd0, rsp0_valid}, {63'd0, pend && pend_owner == 0});
        chk("rsp1_valid", {63'd0, rsp1_valid}, {63'd0, pend && pend_owner == 1});
        if (pend) chk("rsp_rdata", (pend_owner == 1) ? rsp1_rdata : rsp0_rdata, pend_data);
        chk("mem_wen", {56'd0, mem_wen}, {56'd0, ew});
        chk("mem_addr", mem_addr, ea);
        chk("mem_wdata", mem_wdata, ed);
        if (g >= 0) begin
            nw = merge(shadow[ea[12:3]], ed, ew);
            shadow[ea[12:3]] = nw;
            pend = 1; pend_owner = g; pend_data = nw;
            lk = (g == 1) ? v.l1 : v.l0;
            if (lk) lock_own = g;
            else if (lock_own == g) lock_own = -1;
            rr_last_m = g;
        end else begin
            pend = 0;
        end
    endtask

    task automatic tbl_chk(input vec_t v, input int i);
        chk($sformatf("tbl%0d_ready0", i), {63'd0, req0_ready}, {63'd0, v.er0});
        chk($sformatf("tbl%0d_ready1", i), {63'd0, req1_ready}, {63'd0, v.er1});
        chk($sformatf("tbl%0d_rsp0_valid", i), {63'd0, rsp0_valid}, {63'd0, v.ev0});
        chk($sformatf("tbl%0d_rsp1_valid", i), {63'd0, rsp1_valid}, {63'd0, v.ev1});
        if (v.ev0 || v.ev1) chk($sformatf("tbl%0d_rdata", i), v.ev1 ? rsp1_rdata : rsp0_rdata, v.erd);
    endtask

    localparam logic [63:0] DA   = 64'h1122334455667788;
    localparam logic [63:0] DB   = 64'hCAFEBABEDEADBEEF;
    localparam logic [63:0] DC   = 64'h0123456789ABCDEF;
    localparam logic [63:0] ONES = 64'hFFFFFFFFFFFFFFFF;
    localparam logic [63:0] DPRT = 64'hFFFFFFFF89ABCDEF;

    vec_t tbl [16];
    vec_t idle, vr;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem_arr[i] = '0;
            shadow[i]  = '0;
        end
        lock_own = -1; rr_last_m = 1; pend = 0; pend_owner = 0; pend_data = '0;
        rst = 1'b1;
        req0_valid = 0; req0_lock = 0; req0_addr = '0; req0_wdata = '0; req0_wen = '0;
        req1_valid = 0; req1_lock = 0; req1_addr = '0; req1_wdata = '0; req1_wen = '0;
        idle = mk(0,0,64'h0,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 0,0,0,0,64'h0);

        // conflict arbitration, write/read-back, lock hold-off, partial write, idle
        tbl[0]  = mk(1,0,64'h100,8'h00,64'h0, 1,0,64'h100,8'h00,64'h0, 1,0,0,0,64'h0);
        tbl[1]  = mk(1,0,64'h100,8'h00,64'h0, 1,0,64'h100,8'h00,64'h0, !RR,RR,1,0,64'h0);
        tbl[2]  = mk(1,0,64'h100,8'h00,64'h0, 1,0,64'h100,8'h00,64'h0, 1,0,!RR,RR,64'h0);
        tbl[3]  = mk(1,0,64'h100,8'h00,64'h0, 1,0,64'h100,8'h00,64'h0, !RR,RR,1,0,64'h0);
        tbl[4]  = mk(1,0,64'h100,8'hFF,DA, 0,0,64'h0,8'h00,64'h0, 1,0,!RR,RR,64'h0);
        tbl[5]  = mk(1,0,64'h100,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 1,0,1,0,DA);
        tbl[6]  = mk(0,0,64'h0,8'h00,64'h0, 1,1,64'h200,8'h00,64'h0, 0,1,1,0,DA);
        tbl[7]  = mk(1,0,64'h100,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 0,0,0,1,64'h0);
        tbl[8]  = mk(1,0,64'h100,8'h00,64'h0, 1,0,64'h200,8'hFF,DB, 0,1,0,0,64'h0);
        tbl[9]  = mk(1,0,64'h100,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 1,0,0,1,DB);
        tbl[10] = mk(0,0,64'h0,8'h00,64'h0, 1,0,64'h300,8'hFF,ONES, 0,1,1,0,DA);
        tbl[11] = mk(0,0,64'h0,8'h00,64'h0, 1,0,64'h300,8'h0F,DC, 0,1,0,1,ONES);
        tbl[12] = mk(0,0,64'h0,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 0,0,0,1,DPRT);
        tbl[13] = idle;
        tbl[14] = idle;
        tbl[15] = idle;

        // reset with a write request presented: no grant, no memory write
        vr = mk(1,1,64'h100,8'hFF,ONES, 1,0,64'h200,8'hFF,ONES, 0,0,0,0,64'h0);
        run_cycle(vr, 1'b1);
        run_cycle(vr, 1'b1);
        chk("reset_mem_wen", {56'd0, mem_wen}, 64'd0);
        chk("reset_rsp0_valid", {63'd0, rsp0_valid}, 64'd0);

        for (int i = 0; i < 16; i++) begin
            run_cycle(tbl[i], 1'b0);
            tbl_chk(tbl[i], i);
        end

        // reset while a locked port-0 read response is pending
        run_cycle(mk(1,1,64'h100,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 0,0,0,0,64'h0), 1'b0);
        chk("lock_acc_ready0", {63'd0, req0_ready}, 64'd1);
        run_cycle(mk(1,1,64'h100,8'h00,64'h0, 1,0,64'h200,8'h00,64'h0, 0,0,0,0,64'h0), 1'b0);
        chk("locked_ready1", {63'd0, req1_ready}, 64'd0);
        run_cycle(mk(1,0,64'h100,8'hFF,DC, 0,0,64'h0,8'h00,64'h0, 0,0,0,0,64'h0), 1'b1);
        chk("rst_drop_rsp0", {63'd0, rsp0_valid}, 64'd0);
        run_cycle(mk(0,0,64'h0,8'h00,64'h0, 1,0,64'h200,8'h00,64'h0, 0,0,0,0,64'h0), 1'b0);
        chk("post_rst_ready1", {63'd0, req1_ready}, 64'd1);
        chk("post_rst_rsp0", {63'd0, rsp0_valid}, 64'd0);
        run_cycle(mk(1,0,64'h100,8'h00,64'h0, 0,0,64'h0,8'h00,64'h0, 0,0,0,0,64'h0), 1'b0);
        run_cycle(idle, 1'b0);
        chk("rst_no_write_rdata", rsp0_rdata, DA);

        // random traffic over a small address pool to force collisions and locks
        for (int n = 0; n < 600; n++) begin
            vec_t rv;
            rv = idle;
            rv.v0 = ($urandom_range(0, 9) < 6);
            rv.v1 = ($urandom_range(0, 9) < 6);
            rv.l0 = ($urandom_range(0, 9) < 2);
            rv.l1 = ($urandom_range(0, 9) < 2);
            rv.a0 = 64'h400 + 64'($urandom_range(0, 7)) * 8;
            rv.a1 = 64'h400 + 64'($urandom_range(0, 7)) * 8;
            rv.w0 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            rv.w1 = ($urandom_range(0, 1) == 1) ? 8'($urandom) : 8'h00;
            rv.d0 = {$urandom, $urandom};
            rv.d1 = {$urandom, $urandom};
            run_cycle(rv, ($urandom_range(0, 99) == 0));
        end
        run_cycle(idle, 1'b0);
        run_cycle(idle, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
